playseq_uc_multijogador: RTL and testbench
==========================================

// Module: playseq_uc_multijogador
// PURPOSE
// - Control unit (Moore FSM) for PlaySeq with N players taking turns, per-player lives and an LED preview before each attempt.
// - An error or timeout costs the current player one life and passes the turn; the round replays. The game ends on full sequence or all players out.
// - Drives the existing datapath counters (E, S, R, T, TL) and feeds per-player status to the display.
// PARAMETERS
// - N_JOG   2  number of players, 1..8
// - VIDAS   3  lives loaded per player at game start, >=1
// - W_J     clog2(N_JOG) (min 1)  player-index width
// - W_V     clog2(VIDAS+1)  lives-count width
// - TROCA_R 1  1: turn passes after each won round; 0: player keeps turn until a life is lost
// PORTS
// - clock  in  1  system clock
// - reset  in  1  asynchronous, active-high; FSM->INICIAL, all regs cleared
// - jogar/tem_jogada  in  1  start/restart; player input registered this cycle
// - igualE/fimE/fimS  in  1  entry matches; last entry of round; last round of sequence
// - timeout/timeoutL  in  1  play timer expired; LED timer expired
// - zeraE/contaE, zeraS/contaS, zeraR/registraR, zeraT/contaT, zeraTL/contaTL  out  1  datapath counter/register controls
// - ativa_leds  out  1  preview LED shows memory entry E
// - jogador  out  W_J  current player index
// - vidas_atual  out  W_V  lives of current player
// - vivo  out  N_JOG  bit i = player i has lives>0
// - perdeu_vida  out  1  one-cycle pulse per life lost
// - ganhou/perdeu/pronto  out  1  end-of-game flags
// - vencedor  out  W_J  winning player, valid while ganhou
// - db_estado  out  5  state encoding (debug)
// BEHAVIOUR
// - Reset: state=INICIAL(00), jogador=0, vencedor=0, vidas[*]=0 (vivo=0); all pulse outputs 0.
// - Outputs are decoded from state only; counter controls are asserted in the cycle they act.
// - INICIAL 00: zeraE,zeraS,zeraR,zeraT,zeraTL. jogar->PREPARA.
// - PREPARA 01: same zeros; vidas[*]<=VIDAS, jogador<=0. ->MOSTRA.
// - MOSTRA 02: ativa_leds,contaTL. timeoutL: fimE->INICIA, else AVANCA.
// - AVANCA 03: contaE,zeraTL ->APAGADO 04. APAGADO: contaTL; timeoutL->LIGA 05. LIGA: zeraTL ->MOSTRA.
// - INICIA 06: zeraE,zeraT,zeraTL ->ESPERA.
// - ESPERA 07: contaT. timeout has priority over tem_jogada: timeout->PERDE; tem_jogada->REGISTRA 08.
// - REGISTRA: registraR ->COMPARA 09.
// - COMPARA: !igualE->PERDE; !fimE->PROXIMO 0A; fimE&fimS->FIM_G; fimE&!fimS->NOVA_R.
// - PROXIMO: contaE,zeraT ->ESPERA.
// - NOVA_R 0B: contaS,zeraE,zeraT ->(TROCA_R ? TROCA : MOSTRA).
// - PERDE 0C: vidas[jogador]<=vidas-1, saturating at 0; perdeu_vida; zeraE,zeraT ->TROCA.
// - TROCA 0D: zeraE,zeraTL,zeraT. Searches players jogador+1..jogador+N_JOG mod N_JOG, using vidas after any PERDE update.
//   - First with vivo=1 becomes jogador ->MOSTRA; may be the same player if only that one is alive.
//   - No player alive ->FIM_P.
// - FIM_G 1A: pronto,ganhou,vencedor=jogador (held). FIM_P 1F: pronto,perdeu. Both: jogar->PREPARA.
// - jogar is ignored outside INICIAL/FIM_*. Unused encodings ->INICIAL. Reset mid-game aborts in the same cycle.
// - N_JOG=1: TROCA always reselects player 0 until vidas=0.
// STRUCTURE
// - Shared include playseq_defs.vh: state encodings and the clog2 function.
// - Sub-module playseq_seletor_jogador: combinational rotating priority search (vivo, jogador) -> (prox, algum_vivo).
// - FSM, lives register array and jogador register stay in this module.
// TESTING
// - N_JOG=2,VIDAS=3,TROCA_R=1; all 4 rounds correct -> NOVA_R alternates jogador 0,1,0; FIM_G with vencedor=1 after round 4.
// - P0 errs in round 1 -> one perdeu_vida pulse, vivo=11, vidas[0]=2, jogador=1, round 1 replayed (S unchanged).
// - timeout and tem_jogada same cycle in ESPERA -> PERDE taken, no registraR.
// - VIDAS=1: P0 errs then P1 times out -> vivo=00, FIM_P; pronto=perdeu=1; jogar -> PREPARA reloads vidas=1.
// - N_JOG=3 with P1 dead, P0 loses -> jogador skips to 2; TROCA_R=0 -> jogador unchanged across NOVA_R.
// - reset asserted in MOSTRA -> db_estado=00, vivo=0, ativa_leds=0 without waiting for a clock edge.

Source files
------------

// File: rtl/playseq_uc_multijogador_pkg.sv
// Shared definitions for the PlaySeq multiplayer control unit: state
// encodings (kept numerically identical to the legacy include) and width helpers.
package playseq_uc_multijogador_pkg;

  localparam logic [4:0] INICIAL  = 5'h00;
  localparam logic [4:0] PREPARA  = 5'h01;
  localparam logic [4:0] MOSTRA   = 5'h02;
  localparam logic [4:0] AVANCA   = 5'h03;
  localparam logic [4:0] APAGADO  = 5'h04;
  localparam logic [4:0] LIGA     = 5'h05;
  localparam logic [4:0] INICIA   = 5'h06;
  localparam logic [4:0] ESPERA   = 5'h07;
  localparam logic [4:0] REGISTRA = 5'h08;
  localparam logic [4:0] COMPARA  = 5'h09;
  localparam logic [4:0] PROXIMO  = 5'h0A;
  localparam logic [4:0] NOVA_R   = 5'h0B;
  localparam logic [4:0] PERDE    = 5'h0C;
  localparam logic [4:0] TROCA    = 5'h0D;
  localparam logic [4:0] FIM_G    = 5'h1A;
  localparam logic [4:0] FIM_P    = 5'h1F;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/playseq_seletor_jogador.sv
// Rotating priority search: finds the first living player after the
// current one, wrapping around, possibly landing on the current player itself.
module playseq_seletor_jogador
  import playseq_uc_multijogador_pkg::*;
#(
  parameter int unsigned N_JOG = 2,
  parameter int unsigned W_J   = 1
) (
  input  logic [N_JOG-1:0] vivo,
  input  logic [W_J-1:0]   jogador,
  output logic [W_J-1:0]   prox,
  output logic             algum_vivo
);

  logic [W_J-1:0] idx;

  // Scan from the farthest candidate down so the nearest living one wins.
  always_comb begin
    prox       = jogador;
    algum_vivo = 1'b0;
    idx        = '0;
    for (int unsigned k = N_JOG; k >= 1; k--) begin
      idx = W_J'((32'(jogador) + k) % N_JOG);
      if (vivo[idx]) begin
        prox       = idx;
        algum_vivo = 1'b1;
      end
    end
  end

endmodule

// File: rtl/playseq_uc_multijogador.sv
// PlaySeq control unit (Moore FSM) for N players taking turns, with per-player
// lives, LED preview before each attempt and end-of-game detection.
module playseq_uc_multijogador
  import playseq_uc_multijogador_pkg::*;
#(
  parameter int unsigned N_JOG   = 2,
  parameter int unsigned VIDAS   = 3,
  parameter int unsigned W_J     = clog2_min1(N_JOG),
  parameter int unsigned W_V     = clog2(VIDAS + 1),
  parameter int unsigned TROCA_R = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jogar,
  input  logic             tem_jogada,
  input  logic             igualE,
  input  logic             fimE,
  input  logic             fimS,
  input  logic             timeout,
  input  logic             timeoutL,
  output logic             zeraE,
  output logic             contaE,
  output logic             zeraS,
  output logic             contaS,
  output logic             zeraR,
  output logic             registraR,
  output logic             zeraT,
  output logic             contaT,
  output logic             zeraTL,
  output logic             contaTL,
  output logic             ativa_leds,
  output logic [W_J-1:0]   jogador,
  output logic [W_V-1:0]   vidas_atual,
  output logic [N_JOG-1:0] vivo,
  output logic             perdeu_vida,
  output logic             ganhou,
  output logic             perdeu,
  output logic             pronto,
  output logic [W_J-1:0]   vencedor,
  output logic [4:0]       db_estado
);

  logic [4:0]     estado;
  logic [4:0]     prox_estado;
  logic [W_V-1:0] vidas [N_JOG];
  logic [W_J-1:0] jogador_r;
  logic [W_J-1:0] vencedor_r;
  logic [W_J-1:0] prox_jog;
  logic           algum_vivo;

  always_comb begin
    vivo = '0;
    for (int unsigned i = 0; i < N_JOG; i++) vivo[i] = (vidas[i] != '0);
  end

  playseq_seletor_jogador #(
    .N_JOG (N_JOG),
    .W_J   (W_J)
  ) u_seletor (
    .vivo       (vivo),
    .jogador    (jogador_r),
    .prox       (prox_jog),
    .algum_vivo (algum_vivo)
  );

  always_comb begin
    prox_estado = INICIAL;
    case (estado)
      INICIAL:  prox_estado = jogar ? PREPARA : INICIAL;
      PREPARA:  prox_estado = MOSTRA;
      MOSTRA: begin
        if (timeoutL) prox_estado = fimE ? INICIA : AVANCA;
        else          prox_estado = MOSTRA;
      end
      AVANCA:   prox_estado = APAGADO;
      APAGADO:  prox_estado = timeoutL ? LIGA : APAGADO;
      LIGA:     prox_estado = MOSTRA;
      INICIA:   prox_estado = ESPERA;
      ESPERA: begin
        if (timeout)         prox_estado = PERDE;
        else if (tem_jogada) prox_estado = REGISTRA;
        else                 prox_estado = ESPERA;
      end
      REGISTRA: prox_estado = COMPARA;
      COMPARA: begin
        if (!igualE)   prox_estado = PERDE;
        else if (!fimE) prox_estado = PROXIMO;
        else if (fimS)  prox_estado = FIM_G;
        else            prox_estado = NOVA_R;
      end
      PROXIMO:  prox_estado = ESPERA;
      NOVA_R:   prox_estado = (TROCA_R != 0) ? TROCA : MOSTRA;
      PERDE:    prox_estado = TROCA;
      TROCA:    prox_estado = algum_vivo ? MOSTRA : FIM_P;
      FIM_G:    prox_estado = jogar ? PREPARA : FIM_G;
      FIM_P:    prox_estado = jogar ? PREPARA : FIM_P;
      default:  prox_estado = INICIAL;
    endcase
  end

  // TROCA sees the lives already decremented by PERDE one cycle earlier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      jogador_r  <= '0;
      vencedor_r <= '0;
      for (int unsigned i = 0; i < N_JOG; i++) vidas[i] <= '0;
    end else begin
      estado <= prox_estado;
      case (estado)
        PREPARA: begin
          for (int unsigned i = 0; i < N_JOG; i++) vidas[i] <= W_V'(VIDAS);
          jogador_r <= '0;
        end
        PERDE: begin
          if (vidas[jogador_r] != '0) vidas[jogador_r] <= vidas[jogador_r] - 1'b1;
        end
        TROCA: begin
          if (algum_vivo) jogador_r <= prox_jog;
        end
        COMPARA: begin
          if (prox_estado == FIM_G) vencedor_r <= jogador_r;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    zeraE       = 1'b0;
    contaE      = 1'b0;
    zeraS       = 1'b0;
    contaS      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    zeraT       = 1'b0;
    contaT      = 1'b0;
    zeraTL      = 1'b0;
    contaTL     = 1'b0;
    ativa_leds  = 1'b0;
    perdeu_vida = 1'b0;
    ganhou      = 1'b0;
    perdeu      = 1'b0;
    pronto      = 1'b0;
    case (estado)
      INICIAL, PREPARA: begin
        zeraE  = 1'b1;
        zeraS  = 1'b1;
        zeraR  = 1'b1;
        zeraT  = 1'b1;
        zeraTL = 1'b1;
      end
      MOSTRA: begin
        ativa_leds = 1'b1;
        contaTL    = 1'b1;
      end
      AVANCA: begin
        contaE = 1'b1;
        zeraTL = 1'b1;
      end
      APAGADO:  contaTL = 1'b1;
      LIGA:     zeraTL  = 1'b1;
      INICIA: begin
        zeraE  = 1'b1;
        zeraT  = 1'b1;
        zeraTL = 1'b1;
      end
      ESPERA:   contaT    = 1'b1;
      REGISTRA: registraR = 1'b1;
      PROXIMO: begin
        contaE = 1'b1;
        zeraT  = 1'b1;
      end
      NOVA_R: begin
        contaS = 1'b1;
        zeraE  = 1'b1;
        zeraT  = 1'b1;
      end
      PERDE: begin
        perdeu_vida = 1'b1;
        zeraE       = 1'b1;
        zeraT       = 1'b1;
      end
      TROCA: begin
        zeraE  = 1'b1;
        zeraTL = 1'b1;
        zeraT  = 1'b1;
      end
      FIM_G: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_P: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign jogador     = jogador_r;
  assign vidas_atual = vidas[jogador_r];
  assign vencedor    = vencedor_r;
  assign db_estado   = estado;

endmodule

// File: tb/tb_playseq_uc_multijogador.sv
// Bench for the PlaySeq multiplayer control unit: random games against a
// game-level model plus table-driven turn/lives sequences on two small configurations.
module tb_playseq_uc_multijogador;

  localparam int M_N    = 2;
  localparam int M_V    = 3;
  localparam int M_TR   = 1;
  localparam int ROUNDS = 4;

  localparam logic [4:0] S_INICIAL  = 5'h00;
  localparam logic [4:0] S_PREPARA  = 5'h01;
  localparam logic [4:0] S_MOSTRA   = 5'h02;
  localparam logic [4:0] S_ESPERA   = 5'h07;
  localparam logic [4:0] S_REGISTRA = 5'h08;
  localparam logic [4:0] S_NOVA_R   = 5'h0B;
  localparam logic [4:0] S_PERDE    = 5'h0C;
  localparam logic [4:0] S_TROCA    = 5'h0D;
  localparam logic [4:0] S_FIM_G    = 5'h1A;
  localparam logic [4:0] S_FIM_P    = 5'h1F;

  localparam int A_JOGAR = 0;
  localparam int A_OK    = 1;
  localparam int A_ERR   = 2;
  localparam int A_TMO   = 3;
  localparam int A_BOTH  = 4;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- main DUT (2 players, 3 lives, turn passes per round)
  logic jogar, tem_jogada, igualE, timeout;
  logic fimE, fimS, timeoutL;
  logic zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT, zeraTL, contaTL;
  logic ativa_leds, perdeu_vida, ganhou, perdeu, pronto;
  logic [0:0] jogador, vencedor;
  logic [1:0] vidas_atual;
  logic [1:0] vivo;
  logic [4:0] db_estado;

  playseq_uc_multijogador #(.N_JOG(M_N), .VIDAS(M_V), .TROCA_R(M_TR)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
    .igualE(igualE), .fimE(fimE), .fimS(fimS), .timeout(timeout), .timeoutL(timeoutL),
    .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR),
    .registraR(registraR), .zeraT(zeraT), .contaT(contaT), .zeraTL(zeraTL), .contaTL(contaTL),
    .ativa_leds(ativa_leds), .jogador(jogador), .vidas_atual(vidas_atual), .vivo(vivo),
    .perdeu_vida(perdeu_vida), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .vencedor(vencedor), .db_estado(db_estado)
  );

  // Behavioural datapath: entry/round/LED counters driven by the DUT controls.
  int dp_e, dp_s, dp_tl;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dp_e <= 0; dp_s <= 0; dp_tl <= 0;
    end else begin
      if (zeraE) dp_e <= 0; else if (contaE) dp_e <= dp_e + 1;
      if (zeraS) dp_s <= 0; else if (contaS) dp_s <= dp_s + 1;
      if (zeraTL) dp_tl <= 0; else if (contaTL) dp_tl <= dp_tl + 1;
    end
  end
  assign fimE     = (dp_e == dp_s);
  assign fimS     = (dp_s == ROUNDS - 1);
  assign timeoutL = (dp_tl >= 2);

  // ---------------- small DUTs: [0] 3 players/1 life/turn per round, [1] 2 players/1 life/keep turn
  logic       s_jogar [2], s_tem [2], s_tmo [2], s_igual [2];
  logic [4:0] s_st [2];
  logic       s_pv [2], s_reg [2], s_pronto [2], s_perdeu [2], s_vid [2];
  logic [2:0] s_jog [2], s_vivo [2];
  logic [1:0] b_jog, b_venc;
  logic [2:0] b_vivo;
  logic       b_vid, c_jog, c_venc, c_vid;
  logic [1:0] c_vivo;
  logic [10:0] b_ctl, c_ctl;
  logic [1:0]  b_misc, c_misc;

  playseq_uc_multijogador #(.N_JOG(3), .VIDAS(1), .TROCA_R(1)) dut_b (
    .clock(clock), .reset(reset), .jogar(s_jogar[0]), .tem_jogada(s_tem[0]),
    .igualE(s_igual[0]), .fimE(1'b1), .fimS(1'b0), .timeout(s_tmo[0]), .timeoutL(1'b1),
    .zeraE(b_ctl[0]), .contaE(b_ctl[1]), .zeraS(b_ctl[2]), .contaS(b_ctl[3]), .zeraR(b_ctl[4]),
    .registraR(s_reg[0]), .zeraT(b_ctl[5]), .contaT(b_ctl[6]), .zeraTL(b_ctl[7]), .contaTL(b_ctl[8]),
    .ativa_leds(b_ctl[9]), .jogador(b_jog), .vidas_atual(b_vid), .vivo(b_vivo),
    .perdeu_vida(s_pv[0]), .ganhou(b_misc[0]), .perdeu(s_perdeu[0]), .pronto(s_pronto[0]),
    .vencedor(b_venc), .db_estado(s_st[0])
  );

  playseq_uc_multijogador #(.N_JOG(2), .VIDAS(1), .TROCA_R(0)) dut_c (
    .clock(clock), .reset(reset), .jogar(s_jogar[1]), .tem_jogada(s_tem[1]),
    .igualE(s_igual[1]), .fimE(1'b1), .fimS(1'b0), .timeout(s_tmo[1]), .timeoutL(1'b1),
    .zeraE(c_ctl[0]), .contaE(c_ctl[1]), .zeraS(c_ctl[2]), .contaS(c_ctl[3]), .zeraR(c_ctl[4]),
    .registraR(s_reg[1]), .zeraT(c_ctl[5]), .contaT(c_ctl[6]), .zeraTL(c_ctl[7]), .contaTL(c_ctl[8]),
    .ativa_leds(c_ctl[9]), .jogador(c_jog), .vidas_atual(c_vid), .vivo(c_vivo),
    .perdeu_vida(s_pv[1]), .ganhou(c_misc[0]), .perdeu(s_perdeu[1]), .pronto(s_pronto[1]),
    .vencedor(c_venc), .db_estado(s_st[1])
  );

  assign s_jog[0]  = {1'b0, b_jog};
  assign s_jog[1]  = {2'b00, c_jog};
  assign s_vivo[0] = b_vivo;
  assign s_vivo[1] = {1'b0, c_vivo};
  assign s_vid[0]  = b_vid;
  assign s_vid[1]  = c_vid;

  // ---------------- helpers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int next_alive(input int v [M_N], input int j);
    for (int d = 1; d <= M_N; d++)
      if (v[(j + d) % M_N] > 0) return (j + d) % M_N;
    return -1;
  endfunction

  // Apply one action to small DUT d and run it to the next waiting point.
  task automatic s_apply(input int d, input int a, output int pv, output int rg, output bit ok);
    int n;
    pv = 0; rg = 0; ok = 1'b1;
    if (a == A_JOGAR) begin
      s_jogar[d] = 1'b1; step(); s_jogar[d] = 1'b0;
    end else begin
      n = 0;
      while (s_st[d] != S_ESPERA && n < 50) begin step(); n++; end
      if (s_st[d] != S_ESPERA) begin ok = 1'b0; return; end
      s_igual[d] = (a == A_OK || a == A_BOTH);
      s_tem[d]   = (a != A_TMO);
      s_tmo[d]   = (a == A_TMO || a == A_BOTH);
      step();
      s_tem[d] = 1'b0; s_tmo[d] = 1'b0;
    end
    n = 0;
    while (1) begin
      if (s_pv[d])  pv++;
      if (s_reg[d]) rg++;
      if (s_st[d] == S_ESPERA || s_st[d] == S_FIM_P || s_st[d] == S_FIM_G || n >= 60) break;
      step(); n++;
    end
    if (n >= 60) ok = 1'b0;
  endtask

  // One full game on the main DUT; mode 0 random, 1 always correct, 2 first move wrong.
  task automatic run_game(input int mode);
    int m_vid [M_N];
    int m_jog, m_s, m_k, m_end, m_lost, pv_seen, cyc, dly, nacts, a, r, nxt;
    logic [M_N-1:0] mv;
    logic [4:0] st, prev;
    bit done, both_pend;
    jogar = 1'b1; step(); jogar = 1'b0;
    for (int i = 0; i < M_N; i++) m_vid[i] = M_V;
    m_jog = 0; m_s = 0; m_k = 0; m_end = 0; m_lost = 0; pv_seen = 0;
    cyc = 0; dly = 0; nacts = 0; done = 1'b0; both_pend = 1'b0;
    prev = S_INICIAL;
    while (!done && cyc < 4000) begin
      st = db_estado;
      jogar = 1'b0;
      if (both_pend) begin
        chk("both_takes_perde", st, S_PERDE);
        both_pend = 1'b0;
      end
      if (perdeu_vida) pv_seen++;
      if (st == S_MOSTRA && (prev == S_PREPARA || prev == S_TROCA || prev == S_NOVA_R)) begin
        for (int i = 0; i < M_N; i++) mv[i] = (m_vid[i] > 0);
        chk("turn_jogador", jogador, m_jog);
        chk("turn_vidas", vidas_atual, m_vid[m_jog]);
        chk("turn_vivo", vivo, mv);
        chk("turn_round", dp_s, m_s);
      end
      if (st == S_ESPERA) begin
        if (prev != S_ESPERA) dly = $urandom_range(0, 2);
        if (dly == 0) begin
          if (mode == 1) a = A_OK;
          else if (mode == 2 && nacts == 0) a = A_ERR;
          else begin
            r = $urandom_range(0, 99);
            a = (r < 80) ? A_OK : (r < 88) ? A_ERR : (r < 95) ? A_TMO : A_BOTH;
          end
          nacts++;
          igualE     = (a == A_OK || a == A_BOTH);
          tem_jogada = (a != A_TMO);
          timeout    = (a == A_TMO || a == A_BOTH);
          both_pend  = (a == A_BOTH);
          if (a == A_OK) begin
            if (m_k == m_s) begin
              if (m_s == ROUNDS - 1) m_end = 1;
              else begin
                m_s++; m_k = 0;
                if (M_TR != 0) m_jog = next_alive(m_vid, m_jog);
              end
            end else m_k++;
          end else begin
            m_vid[m_jog]--; m_lost++; m_k = 0;
            nxt = next_alive(m_vid, m_jog);
            if (nxt < 0) m_end = 2; else m_jog = nxt;
          end
        end else begin
          dly--;
          tem_jogada = 1'b0; timeout = 1'b0;
          jogar = ($urandom_range(0, 3) == 0);
        end
      end else begin
        tem_jogada = 1'b0; timeout = 1'b0;
      end
      if (st == S_FIM_G || st == S_FIM_P) begin
        chk("end_state", st, (m_end == 1) ? S_FIM_G : S_FIM_P);
        chk("end_pronto", pronto, 1);
        chk("end_ganhou", ganhou, (m_end == 1) ? 1 : 0);
        chk("end_perdeu", perdeu, (m_end == 2) ? 1 : 0);
        chk("end_lives_lost", pv_seen, m_lost);
        if (m_end == 1) chk("end_vencedor", vencedor, m_jog);
        else chk("end_vivo", vivo, 0);
        done = 1'b1;
      end else begin
        prev = st;
        step();
        cyc++;
      end
    end
    if (!done) chk("game_finished_in_budget", 0, 1);
  endtask

  typedef struct {
    int         d;
    int         act;
    logic [4:0] st;
    logic [2:0] jog;
    logic [2:0] vivo;
    logic       vid;
    int         pv;
    int         rg;
    logic [1:0] pp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int pv, rg;
    bit ok;
    reset = 1'b1;
    jogar = 1'b0; tem_jogada = 1'b0; igualE = 1'b0; timeout = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_jogar[i] = 1'b0; s_tem[i] = 1'b0; s_tmo[i] = 1'b0; s_igual[i] = 1'b0;
    end

    tbl[0]  = '{0, A_JOGAR, S_ESPERA, 3'd0, 3'b111, 1'b1, 0, 0, 2'b00};
    tbl[1]  = '{0, A_OK,    S_ESPERA, 3'd1, 3'b111, 1'b1, 0, 1, 2'b00};
    tbl[2]  = '{0, A_ERR,   S_ESPERA, 3'd2, 3'b101, 1'b1, 1, 1, 2'b00};
    tbl[3]  = '{0, A_OK,    S_ESPERA, 3'd0, 3'b101, 1'b1, 0, 1, 2'b00};
    tbl[4]  = '{0, A_ERR,   S_ESPERA, 3'd2, 3'b100, 1'b1, 1, 1, 2'b00};
    tbl[5]  = '{0, A_BOTH,  S_FIM_P,  3'd2, 3'b000, 1'b0, 1, 0, 2'b11};
    tbl[6]  = '{0, A_JOGAR, S_ESPERA, 3'd0, 3'b111, 1'b1, 0, 0, 2'b00};
    tbl[7]  = '{1, A_JOGAR, S_ESPERA, 3'd0, 3'b011, 1'b1, 0, 0, 2'b00};
    tbl[8]  = '{1, A_OK,    S_ESPERA, 3'd0, 3'b011, 1'b1, 0, 1, 2'b00};
    tbl[9]  = '{1, A_TMO,   S_ESPERA, 3'd1, 3'b010, 1'b1, 1, 0, 2'b00};
    tbl[10] = '{1, A_ERR,   S_FIM_P,  3'd1, 3'b000, 1'b0, 1, 1, 2'b11};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_estado", db_estado, S_INICIAL);
    chk("rst_jogador", jogador, 0);
    chk("rst_vencedor", vencedor, 0);
    chk("rst_vivo", vivo, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_leds", ativa_leds, 0);
    chk("rst_perdeu_vida", perdeu_vida, 0);
    chk("rst_zeraE", zeraE, 1);
    chk("rst_b_vivo", s_vivo[0], 0);
    reset = 1'b0;
    step();
    chk("idle_stays_inicial", db_estado, S_INICIAL);

    for (int i = 0; i < 11; i++) begin
      s_apply(tbl[i].d, tbl[i].act, pv, rg, ok);
      chk($sformatf("v%0d_settled", i), ok, 1);
      chk($sformatf("v%0d_estado", i), s_st[tbl[i].d], tbl[i].st);
      chk($sformatf("v%0d_jogador", i), s_jog[tbl[i].d], tbl[i].jog);
      chk($sformatf("v%0d_vivo", i), s_vivo[tbl[i].d], tbl[i].vivo);
      chk($sformatf("v%0d_vidas", i), s_vid[tbl[i].d], tbl[i].vid);
      chk($sformatf("v%0d_perdeu_vida", i), pv, tbl[i].pv);
      chk($sformatf("v%0d_registraR", i), rg, tbl[i].rg);
      chk($sformatf("v%0d_pronto_perdeu", i), {s_pronto[tbl[i].d], s_perdeu[tbl[i].d]}, tbl[i].pp);
    end

    run_game(1);
    chk("all_ok_vencedor", vencedor, 1);
    run_game(2);
    for (int g = 0; g < 8; g++) run_game(0);

    // Reset during the LED preview must abort without a clock edge.
    jogar = 1'b1; step(); jogar = 1'b0;
    step();
    chk("pre_reset_mostra", db_estado, S_MOSTRA);
    chk("pre_reset_leds", ativa_leds, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_estado", db_estado, S_INICIAL);
    chk("async_rst_vivo", vivo, 0);
    chk("async_rst_leds", ativa_leds, 0);
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
